// File: rtl/prog_loader_if.sv
// Byte-stream handshake carrying a program frame into the loader.
// The producer drives data/valid; the loader answers with ready.
interface prog_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// Program loader and instruction store: validates a framed byte stream,
// writes it into instruction memory, then releases the core to fetch by pc.
module prog_loader #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  prog_loader_if.slave  stream,
  input  logic [7:0]    pc,
  output logic [7:0]    inst_code,
  output logic          core_run,
  output logic          load_err,
  output logic [AW:0]   words_loaded
);

  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LENS,
    DATA,
    CSUM,
    RUN,
    ERR
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [7:0]  mem [DEPTH];
  logic [7:0]  sum;
  logic [AW:0] count;
  logic [AW:0] len;

  logic        fire;
  logic        len_bad;
  logic        pc_ok;
  logic [AW:0] count_inc;
  logic [7:0]  sum_next;

  assign fire      = stream.in_valid && stream.in_ready;
  assign count_inc = count + (AW+1)'(1);
  assign sum_next  = sum + stream.in_data;
  assign len_bad   = (stream.in_data == 8'd0) ||
                     ({1'b0, stream.in_data} > 9'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst || load_start) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // in_ready, core_run and load_err are pure decodes of the current state.
  always_comb begin
    next_state      = state;
    stream.in_ready = 1'b0;
    core_run        = 1'b0;
    load_err        = 1'b0;
    case (state)
      IDLE: begin
        stream.in_ready = 1'b1;
        if (fire && stream.in_data == SYNC) begin
          next_state = LENS;
        end
      end
      LENS: begin
        stream.in_ready = 1'b1;
        if (fire) begin
          next_state = len_bad ? ERR : DATA;
        end
      end
      DATA: begin
        stream.in_ready = 1'b1;
        if (fire && count_inc == len) begin
          next_state = CSUM;
        end
      end
      CSUM: begin
        stream.in_ready = 1'b1;
        if (fire) begin
          next_state = (sum_next == 8'd0) ? RUN : ERR;
        end
      end
      RUN: begin
        core_run = 1'b1;
      end
      ERR: begin
        load_err = 1'b1;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Restart wipes the whole store so a partial frame never reaches the core.
  always_ff @(posedge clk) begin
    if (rst || load_start) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
      sum   <= 8'h00;
      count <= '0;
      len   <= '0;
    end else if (fire) begin
      case (state)
        LENS: begin
          if (!len_bad) begin
            len   <= stream.in_data[AW:0];
            sum   <= stream.in_data;
            count <= '0;
          end
        end
        DATA: begin
          mem[count[AW-1:0]] <= stream.in_data;
          sum                <= sum_next;
          count              <= count_inc;
        end
        default: begin
        end
      endcase
    end
  end

  assign words_loaded = count;

  assign pc_ok     = ({1'b0, pc} < 9'(DEPTH));
  assign inst_code = (core_run && pc_ok) ? mem[pc[AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of frames fed through a
// scoreboard queue, plus hand sequences for abort and reset-in-RUN.
module tb_prog_loader;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  typedef struct {
    int          id;
    int          first;
    int          n;
    bit          gaps;
    bit          exp_run;
    bit          exp_err;
    int          exp_words;
    logic [63:0] exp_mem;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [7:0]    pc;
  logic [7:0]    inst_code;
  logic          core_run;
  logic          load_err;
  logic [AW:0]   words_loaded;

  prog_loader_if stream ();

  prog_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .stream       (stream),
    .pc           (pc),
    .inst_code    (inst_code),
    .core_run     (core_run),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  logic [7:0] pool [$];
  vec_t       vecs [8];
  vec_t       exp_q [$];
  int         total = 0;
  int         bad   = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Frame bytes are right-aligned in 'bytes', first byte in the highest slot.
  task automatic addVec(input int idx, input logic [127:0] bytes, input int n,
                        input bit gaps, input bit run, input bit err,
                        input int words, input logic [63:0] mem_img);
    vecs[idx].id    = idx;
    vecs[idx].first = pool.size();
    for (int i = 0; i < n; i++) begin
      pool.push_back(bytes[8*(n-1-i) +: 8]);
    end
    vecs[idx].n         = n;
    vecs[idx].gaps      = gaps;
    vecs[idx].exp_run   = run;
    vecs[idx].exp_err   = err;
    vecs[idx].exp_words = words;
    vecs[idx].exp_mem   = mem_img;
  endtask

  task automatic sendByte(input logic [7:0] b);
    stream.in_valid = 1'b1;
    stream.in_data  = b;
    tick();
    stream.in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      sendByte(pool[v.first + i]);
      if (v.gaps && i < v.n - 1) begin
        stream.in_data = 8'hA5;
        tick();
      end
    end
    exp_q.push_back(v);
  endtask

  task automatic checkFrame;
    vec_t e;
    int   waited;
    logic [7:0] want;
    e = exp_q.pop_front();
    waited = 0;
    while (!(core_run || load_err) && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput($sformatf("v%0d_latency", e.id), waited, 0);
    checkOutput($sformatf("v%0d_core_run", e.id), int'(core_run), int'(e.exp_run));
    checkOutput($sformatf("v%0d_load_err", e.id), int'(load_err), int'(e.exp_err));
    checkOutput($sformatf("v%0d_in_ready", e.id), int'(stream.in_ready), 0);
    checkOutput($sformatf("v%0d_words", e.id), int'(words_loaded), e.exp_words);
    for (int p = 0; p < DEPTH; p++) begin
      pc = 8'(p);
      #1;
      want = e.exp_run ? e.exp_mem[8*p +: 8] : 8'h00;
      checkOutput($sformatf("v%0d_inst_pc%0d", e.id, p), int'(inst_code), int'(want));
    end
    pc = 8'd9;
    #1;
    checkOutput($sformatf("v%0d_inst_pc9", e.id), int'(inst_code), 0);
    pc = 8'd0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_in_ready"}, int'(stream.in_ready), 1);
    checkOutput({tag, "_core_run"}, int'(core_run), 0);
    checkOutput({tag, "_load_err"}, int'(load_err), 0);
    checkOutput({tag, "_words"}, int'(words_loaded), 0);
    checkOutput({tag, "_inst"}, int'(inst_code), 0);
  endtask

  task automatic pulseLoadStart;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    load_start      = 1'b0;
    pc              = 8'd0;
    stream.in_valid = 1'b0;
    stream.in_data  = 8'h00;

    addVec(0, 128'hA5_04_21_22_E4_EC_E9, 7, 1'b0, 1'b1, 1'b0, 4, 64'h00000000_ECE42221);
    addVec(1, 128'hA5_04_21_22_E4_EC_E8, 7, 1'b0, 1'b0, 1'b1, 4, 64'h0);
    addVec(2, 128'hA5_00, 2, 1'b0, 1'b0, 1'b1, 0, 64'h0);
    addVec(3, 128'hA5_09, 2, 1'b0, 1'b0, 1'b1, 0, 64'h0);
    addVec(4, 128'hA5_08_01_02_03_04_05_06_07_08_D4, 11, 1'b0, 1'b1, 1'b0, 8,
           64'h08070605_04030201);
    addVec(5, 128'h3C_FF_A5_02_21_22_BB, 7, 1'b1, 1'b1, 1'b0, 2, 64'h00000000_00002221);
    addVec(6, 128'hA5_01_77_88, 4, 1'b0, 1'b1, 1'b0, 1, 64'h00000000_00000077);

    tick();
    tick();
    rst = 1'b0;
    checkIdle("reset");

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      checkFrame();
      pulseLoadStart();
      checkIdle($sformatf("v%0d_restart", i));
    end

    // Abort mid-DATA, with a sync byte offered on the aborting edge.
    sendByte(8'hA5);
    sendByte(8'h04);
    sendByte(8'h11);
    sendByte(8'h22);
    checkOutput("abort_mid_words", int'(words_loaded), 2);
    stream.in_valid = 1'b1;
    stream.in_data  = 8'hA5;
    pulseLoadStart();
    stream.in_valid = 1'b0;
    checkIdle("abort");
    applyStimulus(vecs[6]);
    checkFrame();

    // Reset while running.
    pc  = 8'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkIdle("rst_in_run");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
